// File: rtl/fft_stream_ctrl.sv
// Streaming load/compute/unload controller wrapped around the 64-point in-place butterfly core.
// Build option FFT_STREAM_BITREV_EN: bit-reversed input write order (DIT core); natural order otherwise.
module fft_stream_ctrl #(
   parameter int D_WIDTH        = 64,
   parameter int LOG_2_WIDTH    = 6,
   parameter int COMPUTE_CYCLES = 384
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [15:0]                    in_re,
   input  logic [15:0]                    in_im,
   output logic [D_WIDTH-1:0][15:0]       fft_in_re,
   output logic [D_WIDTH-1:0][15:0]       fft_in_im,
   output logic                           fft_start,
   input  logic [D_WIDTH-1:0][15:0]       fft_out_re,
   input  logic [D_WIDTH-1:0][15:0]       fft_out_im,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [15:0]                    out_re,
   output logic [15:0]                    out_im,
   output logic [LOG_2_WIDTH-1:0]         out_index,
   output logic                           out_last,
   output logic                           busy
);

   localparam int CYC_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
   localparam logic [CYC_W-1:0]       CC_LAST  = CYC_W'(COMPUTE_CYCLES - 1);
   localparam logic [LOG_2_WIDTH-1:0] IDX_LAST = LOG_2_WIDTH'(D_WIDTH - 1);

   localparam logic [2:0] S_LOAD    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_COMPUTE = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_UNLOAD  = 3'd4;

   logic [2:0]                r_state;
   logic [LOG_2_WIDTH-1:0]    r_load_cnt;
   logic [CYC_W-1:0]          r_cyc_cnt;
   logic [LOG_2_WIDTH-1:0]    r_out_cnt;
   logic [D_WIDTH-1:0][15:0]  r_ibuf_re;
   logic [D_WIDTH-1:0][15:0]  r_ibuf_im;
   logic [D_WIDTH-1:0][15:0]  r_obuf_re;
   logic [D_WIDTH-1:0][15:0]  r_obuf_im;

   logic                      w_in_fire;
   logic                      w_out_fire;
   logic [LOG_2_WIDTH-1:0]    w_wr_idx;

   function automatic logic [LOG_2_WIDTH-1:0] f_wr_idx(input logic [LOG_2_WIDTH-1:0] k);
      logic [LOG_2_WIDTH-1:0] r;
`ifdef FFT_STREAM_BITREV_EN
      for (int b = 0; b < LOG_2_WIDTH; b++) r[b] = k[LOG_2_WIDTH-1-b];
`else
      r = k;
`endif
      return r;
   endfunction

   // in_ready is masked by rst so nothing is accepted while reset is held in LOAD
   assign in_ready   = (r_state == S_LOAD) && !rst;
   assign w_in_fire  = in_valid && in_ready;
   assign out_valid  = (r_state == S_UNLOAD);
   assign w_out_fire = out_valid && out_ready;
   assign w_wr_idx   = f_wr_idx(r_load_cnt);

   assign fft_start  = (r_state == S_START);
   assign busy       = (r_state != S_LOAD);
   assign fft_in_re  = r_ibuf_re;
   assign fft_in_im  = r_ibuf_im;

   assign out_re     = r_obuf_re[r_out_cnt];
   assign out_im     = r_obuf_im[r_out_cnt];
   assign out_index  = r_out_cnt;
   assign out_last   = out_valid && (r_out_cnt == IDX_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_LOAD;
         r_load_cnt <= '0;
         r_cyc_cnt  <= '0;
         r_out_cnt  <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (w_in_fire) begin
                  if (r_load_cnt == IDX_LAST) begin
                     r_load_cnt <= '0;
                     r_state    <= S_START;
                  end else begin
                     r_load_cnt <= r_load_cnt + 1'b1;
                  end
               end
            end
            S_START: begin
               r_cyc_cnt <= '0;
               r_state   <= S_COMPUTE;
            end
            S_COMPUTE: begin
               if (r_cyc_cnt == CC_LAST) begin
                  r_state <= S_CAPTURE;
               end else begin
                  r_cyc_cnt <= r_cyc_cnt + 1'b1;
               end
            end
            S_CAPTURE: begin
               r_out_cnt <= '0;
               r_state   <= S_UNLOAD;
            end
            S_UNLOAD: begin
               if (w_out_fire) begin
                  if (r_out_cnt == IDX_LAST) begin
                     r_out_cnt <= '0;
                     r_state   <= S_LOAD;
                  end else begin
                     r_out_cnt <= r_out_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

   // Sample storage keeps its contents across reset
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_ibuf_re[w_wr_idx] <= in_re;
         r_ibuf_im[w_wr_idx] <= in_im;
      end
      if (!rst && r_state == S_CAPTURE) begin
         r_obuf_re <= fft_out_re;
         r_obuf_im <= fft_out_im;
      end
   end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Self-checking bench for fft_stream_ctrl: frame scenario table, input probe table, output scoreboard.
module tb_fft_stream_ctrl;
   localparam int DW = 64;
   localparam int LW = 6;
   localparam int CC = 384;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid, in_ready, fft_start, out_valid, out_ready, out_last, busy;
   logic [15:0]          in_re, in_im, out_re, out_im;
   logic [DW-1:0][15:0]  fft_in_re, fft_in_im, fft_out_re, fft_out_im;
   logic [LW-1:0]        out_index;

   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   fft_stream_ctrl #(.D_WIDTH(DW), .LOG_2_WIDTH(LW), .COMPUTE_CYCLES(CC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_im(in_im), .fft_in_re(fft_in_re), .fft_in_im(fft_in_im),
      .fft_start(fft_start), .fft_out_re(fft_out_re), .fft_out_im(fft_out_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_index(out_index), .out_last(out_last), .busy(busy)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ecnt);
      end
   endtask

   function automatic int wr(input int k);
      int r;
      r = 0;
`ifdef FFT_STREAM_BITREV_EN
      for (int b = 0; b < LW; b++) r = (r << 1) | ((k >> b) & 1);
`else
      r = k;
`endif
      return r;
   endfunction

   typedef struct {
      int          gap;      // every gap-th cycle in_valid drops (0 = never)
      int          bp;       // 1: out_ready pattern 1,0,0,1
      int          hold;     // keep in_valid high after loading
      int          abort;    // 1: rst at cyc_cnt 100, 2: rst after bin 10
      logic [15:0] rb, ib, cb;
      int          exp_lat;  // first out_valid relative to last input edge
      int          exp_cnt;  // outputs delivered before frame ends
   } frame_t;

   typedef struct {
      int          idx;
      logic [15:0] re, im;
   } probe_t;

   logic [63:0] sb_q[$];

   task automatic do_reset_check();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_fft_start", fft_start, 0);
      chk("abort_in_ready", in_ready, 1);
      sb_q.delete();
   endtask

   task automatic run_frame(input frame_t f, input bit probe);
      probe_t      pt[4];
      logic [15:0] ld_re[DW], ld_im[DW];
      logic [63:0] cur, prev, e;
      int k, g, t_last, rel, n_out, n_start, p, ir_bad, mism;
      bit done, aborted, lat_seen, stalled;
`ifdef FFT_STREAM_BITREV_EN
      pt[0] = '{32, 16'd1, 16'd101};  pt[1] = '{1, 16'd32, 16'd132};
      pt[2] = '{63, 16'd63, 16'd163}; pt[3] = '{0, 16'd0, 16'd100};
`else
      pt[0] = '{32, 16'd32, 16'd132}; pt[1] = '{1, 16'd1, 16'd101};
      pt[2] = '{63, 16'd63, 16'd163}; pt[3] = '{0, 16'd0, 16'd100};
`endif
      k = 0; g = 0; t_last = 0;
      for (int guard = 0; guard < DW * 4 && k < DW; guard++) begin
         @(negedge clk);
         in_valid = (f.gap == 0) || ((g % f.gap) != f.gap - 1);
         g++;
         in_re = f.rb + 16'(k);
         in_im = f.ib + 16'(k);
         if (in_valid && in_ready) begin
            ld_re[wr(k)] = in_re;
            ld_im[wr(k)] = in_im;
            k++;
            if (k == DW) t_last = ecnt + 1;
         end
      end
      chk("load_count", k, DW);

      n_out = 0; n_start = 0; p = 0; ir_bad = 0;
      done = 0; aborted = 0; lat_seen = 0; stalled = 0; prev = '0;
      for (int guard = 0; guard < CC + DW * 4 + 20 && !done; guard++) begin
         @(negedge clk);
         rel = ecnt - t_last;
         in_valid = f.hold[0];
         in_re = 16'hBAD0 ^ 16'(rel);
         in_im = 16'h0BAD ^ 16'(rel);
         // core model: outputs are only meaningful in the capture cycle
         for (int i = 0; i < DW; i++) begin
            fft_out_re[i] = (rel == CC + 1) ? f.cb + 16'(i)           : 16'hDEAD ^ 16'(i);
            fft_out_im[i] = (rel == CC + 1) ? f.cb + 16'h1000 + 16'(i) : 16'hBEEF ^ 16'(i);
         end
         if (rel == CC + 1)
            for (int i = 0; i < DW; i++)
               sb_q.push_back({25'd0, f.cb + 16'(i), f.cb + 16'h1000 + 16'(i), 6'(i), (i == DW - 1)});
         if (f.abort == 1 && rel == 101) begin
            do_reset_check(); aborted = 1; done = 1;
         end else if (f.abort == 2 && n_out == 11) begin
            do_reset_check(); aborted = 1; done = 1;
         end else begin
            if (!(in_ready == 1'b0 && busy == 1'b1)) ir_bad++;
            if (fft_start) begin
               n_start++;
               chk("start_time", rel, 0);
               mism = 0;
               for (int i = 0; i < DW; i++)
                  if (fft_in_re[i] !== ld_re[i] || fft_in_im[i] !== ld_im[i]) mism++;
               chk("inbuf_at_start", mism, 0);
               if (probe)
                  for (int j = 0; j < 4; j++) begin
                     chk("probe_re", fft_in_re[pt[j].idx], pt[j].re);
                     chk("probe_im", fft_in_im[pt[j].idx], pt[j].im);
                  end
            end
            out_ready = 1'b0;
            if (out_valid) begin
               cur = {25'd0, out_re, out_im, out_index, out_last};
               if (!lat_seen) begin
                  lat_seen = 1;
                  chk("first_out_lat", rel, f.exp_lat);
               end
               if (stalled) chk("stall_hold", cur, prev);
               prev = cur;
               out_ready = (f.bp == 0) ? 1'b1 : ((p % 4) == 0 || (p % 4) == 3);
               p++;
               stalled = !out_ready;
               if (out_ready) begin
                  if (sb_q.size() == 0) chk("sb_underflow", cur, 0);
                  else begin
                     e = sb_q.pop_front();
                     chk("out_sample", cur, e);
                  end
                  n_out++;
                  if (out_last) done = 1;
               end
            end
         end
      end
      chk("frame_done", done, 1);
      chk("out_count", n_out, f.exp_cnt);
      chk("start_pulses", n_start, 1);
      if (!aborted) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b0;
         chk("in_ready_low_busy", ir_bad, 0);
         chk("post_out_valid", out_valid, 0);
         chk("post_in_ready", in_ready, 1);
         chk("post_busy", busy, 0);
         chk("sb_empty", sb_q.size(), 0);
         mism = 0;
         for (int i = 0; i < DW; i++)
            if (fft_in_re[i] !== ld_re[i] || fft_in_im[i] !== ld_im[i]) mism++;
         chk("inbuf_untouched", mism, 0);
      end
   endtask

   frame_t frames[7];

   initial begin
      frames[0] = '{0, 0, 0, 0, 16'h0000, 16'd100,  16'h1000, CC + 2, 64};
      frames[1] = '{3, 1, 0, 0, 16'h0500, 16'h0A00, 16'h3000, CC + 2, 64};
      frames[2] = '{0, 0, 1, 0, 16'h7F00, 16'h8000, 16'h5000, CC + 2, 64};
      frames[3] = '{0, 0, 0, 1, 16'h1100, 16'h2200, 16'h6000, CC + 2, 0};
      frames[4] = '{0, 0, 0, 0, 16'h1200, 16'h2300, 16'h7000, CC + 2, 64};
      frames[5] = '{3, 0, 1, 2, 16'h1300, 16'h2400, 16'h8000, CC + 2, 11};
      frames[6] = '{3, 1, 0, 0, 16'hFFC0, 16'hFFE0, 16'h9000, CC + 2, 64};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
      fft_out_re = '0; fft_out_im = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fft_start", fft_start, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_index", out_index, 0);
      rst = 1'b0;
      #1;
      chk("rst_release_in_ready", in_ready, 1);

      for (int i = 0; i < 7; i++) run_frame(frames[i], i == 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
